// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locked arbiter sharing one UART transmitter
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 5208,
    parameter int TMR_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                   clk_50MHZ,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [NUM_REQ-1:0]     grant,
    output logic [7:0]             uart_data_in,
    output logic                   uart_tx_start,
    input  logic                   uart_tx_busy,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               last_q, last_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [7:0]         data_q, data_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               to_q, to_d;

    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   pick_cand;
    logic               pick_found;
    logic [IDX_W-1:0]   next_ptr;
    int                 scan_idx;

    // Round-robin pick: scan from the far end down so the valid index closest to rr_ptr wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_cand  = '0;
        scan_idx   = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan_idx = int'(rr_ptr_q) + i;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            pick_cand = IDX_W'(scan_idx);
            if (req_valid[pick_cand]) begin
                pick_found = 1'b1;
                pick_idx   = pick_cand;
            end
        end
    end

    // Requester after the current owner gets first look next round, wrapping at NUM_REQ-1.
    always_comb begin
        next_ptr = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    end

    // Next-state logic: grant, byte hand-off to the transmitter, packet release and stall timeout.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        timer_d  = timer_q;
        last_d   = last_q;
        grant_d  = grant_q;
        ack_d    = '0;
        data_d   = data_q;
        start_d  = 1'b0;
        to_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    timer_d           = '0;
                    state_d           = LOAD;
                end
            end
            LOAD: begin
                if (req_valid[owner_q] && !uart_tx_busy) begin
                    start_d        = 1'b1;
                    data_d         = req_data[{owner_q, 3'b000} +: 8];
                    ack_d[owner_q] = 1'b1;
                    last_d         = req_last[owner_q];
                    timer_d        = '0;
                    state_d        = WAIT_BUSY;
                end else if (!req_valid[owner_q]) begin
                    // Only a missing byte counts as a stall; a busy transmitter does not.
                    if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        to_d     = 1'b1;
                        grant_d  = '0;
                        rr_ptr_d = next_ptr;
                        timer_d  = '0;
                        state_d  = IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    if (last_q) begin
                        grant_d  = '0;
                        rr_ptr_d = next_ptr;
                        state_d  = IDLE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = |grant_d;
    end

    // State and registered outputs; a frame already in the transmitter is left to finish.
    always_ff @(posedge clk_50MHZ or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            timer_q  <= '0;
            last_q   <= 1'b0;
            grant_q  <= '0;
            ack_q    <= '0;
            data_q   <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            timer_q  <= timer_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            data_q   <= data_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            to_q     <= to_d;
        end
    end

    assign req_ack       = ack_q;
    assign grant         = grant_q;
    assign uart_data_in  = data_q;
    assign uart_tx_start = start_q;
    assign busy          = busy_q;
    assign timeout_err   = to_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TMO     = 20;
    localparam int FRAME   = 12;

    logic                 clk_50MHZ = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ack;
    logic [NUM_REQ-1:0]   grant;
    logic [7:0]           uart_data_in;
    logic                 uart_tx_start;
    logic                 uart_tx_busy;
    logic                 busy;
    logic                 timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_cnt [NUM_REQ];
    int to_cnt = 0;

    logic [8:0]  rq [NUM_REQ][$];
    logic [10:0] exp_q [$];
    logic [4:0]  frame_cnt = '0;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_50MHZ(clk_50MHZ), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ack(req_ack), .grant(grant), .uart_data_in(uart_data_in),
        .uart_tx_start(uart_tx_start), .uart_tx_busy(uart_tx_busy), .busy(busy),
        .timeout_err(timeout_err)
    );

    always #10 clk_50MHZ = ~clk_50MHZ;

    always @(posedge clk_50MHZ) cyc <= cyc + 1;

    // Transmitter model: busy from the edge after tx_start for FRAME cycles; not reset by rst.
    always @(posedge clk_50MHZ) begin
        if (frame_cnt != 0) frame_cnt <= frame_cnt - 1'b1;
        else if (uart_tx_start) frame_cnt <= 5'(FRAME);
    end
    assign uart_tx_busy = (frame_cnt != 0);

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requesters: present the head of each queue, pop on ack.
    initial begin
        for (int i = 0; i < NUM_REQ; i++) ack_cnt[i] = 0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk_50MHZ);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ack[i] && !rst) begin
                    check_eq($sformatf("ack_has_byte_%0d", i), 32'(rq[i].size() != 0), 32'd1);
                    if (rq[i].size() != 0) void'(rq[i].pop_front());
                end
                if (rq[i].size() != 0) begin
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = rq[i][0][7:0];
                    req_last[i]         = rq[i][0][8];
                end else begin
                    req_valid[i]        = 1'b0;
                    req_data[8*i +: 8]  = 8'h00;
                    req_last[i]         = 1'b0;
                end
            end
        end
    end

    // Monitor: every tx_start is matched against the next expected {owner, byte}.
    always @(negedge clk_50MHZ) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) if (req_ack[i]) ack_cnt[i]++;
            if (timeout_err) to_cnt++;
            if (uart_tx_start) begin
                check_eq("start_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    logic [10:0] e;
                    logic [3:0]  oh;
                    e  = exp_q.pop_front();
                    oh = 4'b0001 << e[10:8];
                    check_eq("tx_data", 32'(uart_data_in), 32'(e[7:0]));
                    check_eq("tx_grant", 32'(grant), 32'(oh));
                    check_eq("tx_ack", 32'(req_ack), 32'(oh));
                end
            end
        end
    end

    task automatic push(input int r, input logic last, input logic [7:0] d);
        rq[r].push_back({last, d});
        exp_q.push_back({3'(r), d});
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk_50MHZ);
            n++;
        end while (!(exp_q.size() == 0 && !busy && !uart_tx_busy) && n < 2000);
        check_eq({name, "_done"}, 32'(n < 2000), 32'd1);
    endtask

    task automatic wait_sig(input string name, input int which, input logic lvl);
        int n = 0;
        logic s;
        do begin
            @(negedge clk_50MHZ);
            n++;
            case (which)
                0: s = uart_tx_busy;
                1: s = timeout_err;
                2: s = grant[1];
                default: s = uart_tx_start;
            endcase
        end while (s !== lvl && n < 1000);
        check_eq({name, "_reached"}, 32'(n < 1000), 32'd1);
    endtask

    int c0, c1;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk_50MHZ);
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_start", 32'(uart_tx_start), 32'd0);
        check_eq("rst_data", 32'(uart_data_in), 32'd0);
        rst = 1'b0;

        // Single 3-byte packet from requester 0
        push(0, 1'b0, 8'h41);
        push(0, 1'b0, 8'h42);
        push(0, 1'b1, 8'h43);
        wait_idle("t1");
        check_eq("t1_grant_end", 32'(grant), 32'd0);
        check_eq("t1_acks0", 32'(ack_cnt[0]), 32'd3);

        // Round robin from rr_ptr=0: 0, 2, 0, 2
        @(negedge clk_50MHZ) rst = 1'b1;
        @(negedge clk_50MHZ) rst = 1'b0;
        push(0, 1'b1, 8'hA0);
        push(2, 1'b1, 8'hC2);
        push(0, 1'b1, 8'hA0);
        push(2, 1'b1, 8'hC2);
        wait_idle("t2");

        // Packet lock: req 0 arrives during req 1's first frame
        push(1, 1'b0, 8'h11);
        push(1, 1'b1, 8'h12);
        wait_sig("t3_first_start", 3, 1'b1);
        push(0, 1'b1, 8'h05);
        while (grant[1] === 1'b1) begin
            check_eq("t3_no_ack0_locked", 32'(req_ack[0]), 32'd0);
            @(negedge clk_50MHZ);
        end
        wait_idle("t3");

        // Timeout: req 3 stalls after a non-last byte, req 0 pending
        push(3, 1'b0, 8'h33);
        push(0, 1'b1, 8'h07);
        wait_sig("t4_busy_hi", 0, 1'b1);
        wait_sig("t4_busy_lo", 0, 1'b0);
        c0 = cyc;
        wait_sig("t4_timeout", 1, 1'b1);
        c1 = cyc;
        check_eq("t4_timeout_delay", 32'(c1 - c0), 32'(TMO + 1));
        check_eq("t4_grant_revoked", 32'(grant), 32'd0);
        wait_idle("t4");
        check_eq("t4_acks3", 32'(ack_cnt[3]), 32'd1);
        check_eq("t4_acks0", 32'(ack_cnt[0]), 32'd7);
        check_eq("t4_timeouts", 32'(to_cnt), 32'd1);

        // Reset in WAIT_DONE while the transmitter is busy
        push(1, 1'b1, 8'h55);
        wait_sig("t5_busy_hi", 0, 1'b1);
        repeat (2) @(negedge clk_50MHZ);
        check_eq("t5_tx_busy_pre", 32'(uart_tx_busy), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("t5_rst_grant", 32'(grant), 32'd0);
        check_eq("t5_rst_busy", 32'(busy), 32'd0);
        check_eq("t5_rst_data", 32'(uart_data_in), 32'd0);
        check_eq("t5_rst_start", 32'(uart_tx_start), 32'd0);
        check_eq("t5_rst_ack", 32'(req_ack), 32'd0);
        check_eq("t5_rst_to", 32'(timeout_err), 32'd0);
        push(1, 1'b1, 8'h66);
        @(negedge clk_50MHZ) rst = 1'b0;
        wait_sig("t5_grant1", 2, 1'b1);
        check_eq("t5_tx_busy_at_grant", 32'(uart_tx_busy), 32'd1);
        while (uart_tx_busy === 1'b1) begin
            check_eq("t5_no_start_while_busy", 32'(uart_tx_start), 32'd0);
            @(negedge clk_50MHZ);
        end
        wait_idle("t5");
        check_eq("t5_acks1", 32'(ack_cnt[1]), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte-stream requesters, e.g. the GPIO status reporter, the command echo and the debug dump.
- Uses round-robin arbitration with packet lock: a granted requester keeps the transmitter until its byte marked last has been fully sent.
- Drives the transmitter's data_in/tx_start and watches tx_busy.
- Releases a stalled requester after a timeout, so one requester cannot hang the TX path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 5208, clk_50MHZ cycles a granted requester may leave req_valid low mid-packet before release (about 12 bit times at 115200).
- TMR_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width.

Ports:
- clk_50MHZ  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a byte on req_data.
- req_data  in  8*NUM_REQ  byte of requester i at [8i+7:8i]; held until acked.
- req_last  in  NUM_REQ  current byte of requester i ends its packet.
- req_ack  out  NUM_REQ  one-cycle pulse: byte of requester i taken.
- grant  out  NUM_REQ  one-hot current owner, or 0.
- uart_data_in  out  8  to transmitter data_in.
- uart_tx_start  out  1  to transmitter tx_start.
- uart_tx_busy  in  1  from transmitter tx_busy.
- busy  out  1  grant != 0.
- timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (async, asserted at any time):
  - State IDLE; all outputs 0; rr_ptr=0; timer=0; last_r=0.
  - A transmitter frame already in flight completes on its own.
- Outputs: all registered.
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req_valid: choose the first valid index scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - Set grant to that index and go to LOAD; timer=0.
- LOAD (owner g):
  - If req_valid[g] and !uart_tx_busy, on the same edge:
    - uart_tx_start<=1 and uart_data_in<=req_data[g].
    - req_ack[g]<=1 and last_r<=req_last[g].
    - timer<=0; go to WAIT_BUSY.
  - Else if !req_valid[g]: timer increments. When timer==TIMEOUT_CYCLES-1: timeout_err<=1, grant<=0, rr_ptr<=g+1 mod NUM_REQ, go to IDLE.
  - If req_valid[g] is high but uart_tx_busy is also high: wait with no timer increment.
- WAIT_BUSY:
  - uart_tx_start<=0; req_ack<=0.
  - Stay until uart_tx_busy==1, then go to WAIT_DONE.
- WAIT_DONE:
  - Stay until uart_tx_busy==0.
  - Then, if last_r: grant<=0, rr_ptr<=g+1 mod NUM_REQ, go to IDLE.
  - Otherwise go to LOAD.
- Pulse widths: uart_tx_start and req_ack are exactly one cycle per byte. uart_data_in holds its value until the next LOAD capture.
- Latency: req_valid sampled in IDLE at edge N gives grant at N+1 and uart_tx_start/req_ack high in cycle N+2 (no other traffic).
- Packet lock: req_valid of non-owners is ignored until the owner's last byte completes or the owner times out.
- Requester changes: a requester that deasserts req_valid while not granted is simply skipped. A byte is never acked twice.
- Simultaneous valid on several requesters: the rr_ptr order decides. A requester whose packet just ended has the lowest priority next round.
- Wrap-around: rr_ptr increments mod NUM_REQ; from NUM_REQ-1 it goes to 0.
- Single-byte packet (req_last high on the first byte): the grant is released after that one frame.

Test Plan:
- Single packet: req 0 sends 0x41, 0x42, 0x43 with last on 0x43 and a transmitter model.
  - Required: three uart_tx_start pulses with data 0x41/0x42/0x43 and three req_ack[0] pulses.
  - Required: grant=4'b0001 throughout, then 0; busy falls after the third frame.
- Round-robin: req 0 and req 2 continuously offer single-byte packets 0xA0 / 0xC2.
  - Required: transmitted order 0xA0, 0xC2, 0xA0, 0xC2; grants alternate 0001/0100.
- Packet lock: req 1 starts a 2-byte packet (0x11, 0x12 last); req 0 raises valid during the first frame.
  - Required: 0x11, 0x12 are sent before req 0's byte; req_ack[0] stays low until grant[1] drops.
- Timeout: req 3 sends 0x33 (not last), then drops req_valid.
  - Required: exactly TIMEOUT_CYCLES cycles after entering LOAD, one timeout_err pulse and grant=0.
  - Required: pending req 0 is granted next; no further ack to req 3.
- Busy/reset: assert rst in WAIT_DONE while uart_tx_busy=1.
  - Required: all outputs 0 immediately.
  - Required: after release with req_valid[1]=1, grant[1] rises but uart_tx_start stays low until uart_tx_busy falls.
